// File: rtl/shift_add_mul_sequencer_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
// Shift codes are also understood by the RSH shift register.
package shift_add_mul_sequencer_pkg;

    localparam int IN_WIDTH  = 4;
    localparam int OUT_WIDTH = 2 * IN_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SHIFT_HOLD = 2'b00;
    localparam logic [1:0] SHIFT_RSH  = 2'b01;
    localparam logic [1:0] SHIFT_LSH  = 2'b10;

endpackage

// File: rtl/shift_add_mul_sequencer_if.sv
// Request/strobe bundle between control unit, register file and sequencer.
// master drives the request; slave is the sequencer.
interface shift_add_mul_sequencer_if #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 8
);

    logic                 start;
    logic [IN_WIDTH-1:0]  a_in;
    logic [IN_WIDTH-1:0]  b_in;
    logic                 busy;
    logic                 done;
    logic                 ld_a;
    logic                 ld_b;
    logic                 ld_o;
    logic [IN_WIDTH-1:0]  a_out;
    logic [IN_WIDTH-1:0]  b_out;
    logic [1:0]           shift_state;
    logic [OUT_WIDTH-1:0] o_data;
    logic [OUT_WIDTH-1:0] product;

    modport master (
        output start, a_in, b_in,
        input  busy, done, ld_a, ld_b, ld_o,
        input  a_out, b_out, shift_state, o_data, product
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, ld_a, ld_b, ld_o,
        output a_out, b_out, shift_state, o_data, product
    );

endinterface

// File: rtl/shift_add_mul_sequencer_datapath.sv
// Shift-and-add core: multiplicand, multiplier, accumulator, iteration count.
// load primes a new operation; step runs one iteration.
module shift_add_datapath
    import shift_add_mul_sequencer_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [IN_WIDTH-1:0]  a,
    input  logic [IN_WIDTH-1:0]  b,
    output logic [OUT_WIDTH-1:0] acc,
    output logic                 last
);

    localparam int CW = $clog2(IN_WIDTH + 1);

    logic [OUT_WIDTH-1:0] mcand;
    logic [IN_WIDTH-1:0]  mplier;
    logic [CW-1:0]        cnt;
    logic [OUT_WIDTH-1:0] addend;

    assign addend = mplier[0] ? mcand : '0;
    assign last   = (cnt == CW'(IN_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= OUT_WIDTH'(a);
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_add_mul_sequencer.sv
// Sequences register-file loads and RSH shifting for a 4x4 multiply.
// Control FSM and strobe decode; arithmetic lives in shift_add_datapath.
module shift_add_mul_sequencer
    import shift_add_mul_sequencer_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    shift_add_mul_sequencer_if.slave bus
);

    state_t               state;
    state_t               state_n;
    logic                 accept;
    logic                 step;
    logic                 last;
    logic [OUT_WIDTH-1:0] acc;
    logic [IN_WIDTH-1:0]  a_q;
    logic [IN_WIDTH-1:0]  b_q;
    logic [OUT_WIDTH-1:0] product_q;

    assign accept = (state == IDLE) && bus.start;
    assign step   = (state == CALC);

    shift_add_datapath #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_dp (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (step),
        .a     (bus.a_in),
        .b     (bus.b_in),
        .acc   (acc),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = LOAD;
            LOAD:    state_n = CALC;
            CALC:    if (last) state_n = WRITE;
            WRITE:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
        end else begin
            if (accept) begin
                a_q <= bus.a_in;
                b_q <= bus.b_in;
            end
            if (state == WRITE) product_q <= acc;
        end
    end

    // o_data shows acc while writing, then holds the committed product
    assign bus.o_data      = (state == WRITE) ? acc : product_q;
    assign bus.product     = product_q;
    assign bus.a_out       = a_q;
    assign bus.b_out       = b_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.ld_a        = (state == LOAD);
    assign bus.ld_b        = (state == LOAD);
    assign bus.ld_o        = (state == WRITE);
    assign bus.shift_state = (state == CALC) ? SHIFT_RSH : SHIFT_HOLD;

endmodule

// File: tb/tb_shift_add_mul_sequencer.sv
// Directed bench for shift_add_mul_sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_shift_add_mul_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    shift_add_mul_sequencer_if #(.IN_WIDTH(4), .OUT_WIDTH(8)) bus ();

    shift_add_mul_sequencer #(.IN_WIDTH(4), .OUT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".busy"},  32'(bus.busy), 0);
        chk({tag, ".done"},  32'(bus.done), 0);
        chk({tag, ".ld_a"},  32'(bus.ld_a), 0);
        chk({tag, ".ld_b"},  32'(bus.ld_b), 0);
        chk({tag, ".ld_o"},  32'(bus.ld_o), 0);
        chk({tag, ".shift"}, 32'(bus.shift_state), 0);
        chk({tag, ".a_out"}, 32'(bus.a_out), 0);
        chk({tag, ".b_out"}, 32'(bus.b_out), 0);
        chk({tag, ".o_data"}, 32'(bus.o_data), 0);
        chk({tag, ".product"}, 32'(bus.product), 0);
    endtask

    // strobe pattern for cycle c (1..8) of an operation accepted in cycle 0
    task automatic chk_cycle(input string tag, input int c,
                             input logic [7:0] p);
        chk($sformatf("%s.c%0d.ld_a", tag, c), 32'(bus.ld_a), 32'(c == 1));
        chk($sformatf("%s.c%0d.ld_b", tag, c), 32'(bus.ld_b), 32'(c == 1));
        chk($sformatf("%s.c%0d.shift", tag, c), 32'(bus.shift_state),
            (c >= 2 && c <= 5) ? 1 : 0);
        chk($sformatf("%s.c%0d.ld_o", tag, c), 32'(bus.ld_o), 32'(c == 6));
        chk($sformatf("%s.c%0d.done", tag, c), 32'(bus.done), 32'(c == 7));
        chk($sformatf("%s.c%0d.busy", tag, c), 32'(bus.busy), 32'(c <= 7));
        if (c == 6) chk({tag, ".o_data"}, 32'(bus.o_data), 32'(p));
        if (c == 8) chk({tag, ".product"}, 32'(bus.product), 32'(p));
    endtask

    // call at a falling edge; that cycle becomes cycle 0
    task automatic run_op(input string tag, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] p,
                          input bit noise);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk_cycle(tag, c, p);
            if (c == 1) begin
                chk({tag, ".a_out"}, 32'(bus.a_out), 32'(a));
                chk({tag, ".b_out"}, 32'(bus.b_out), 32'(b));
            end
            bus.start = 1'b0;
            if (noise) begin
                bus.a_in = 4'(~a + 4'(c));
                bus.b_in = 4'(b ^ 4'(c));
                if (c == 3) begin
                    bus.start = 1'b1;
                    bus.a_in  = 4'd1;
                    bus.b_in  = 4'd1;
                end
            end
        end
        chk({tag, ".hold_a"}, 32'(bus.a_out), 32'(a));
        chk({tag, ".hold_b"}, 32'(bus.b_out), 32'(b));
        chk({tag, ".hold_o"}, 32'(bus.o_data), 32'(p));
        @(negedge clk);
        chk({tag, ".idle_busy"}, 32'(bus.busy), 0);
        chk({tag, ".idle_done"}, 32'(bus.done), 0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a_in  = 4'd5;
        bus.b_in  = 4'd5;
        repeat (2) @(negedge clk);
        chk_idle_zero("rst");
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk_idle_zero("post_rst");

        run_op("m15x15", 4'd15, 4'd15, 8'd225, 1'b0);
        run_op("m7x0", 4'd7, 4'd0, 8'd0, 1'b0);
        run_op("m0x9", 4'd0, 4'd9, 8'd0, 1'b0);
        run_op("m13x11_noise", 4'd13, 4'd11, 8'd143, 1'b1);

        // back-to-back: start held, operands changed while busy
        bus.start = 1'b1;
        bus.a_in  = 4'd3;
        bus.b_in  = 4'd5;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("b2b.c%0d.done", c), 32'(bus.done),
                32'(c == 7 || c == 15));
            chk($sformatf("b2b.c%0d.busy", c), 32'(bus.busy),
                32'(c != 8 && c != 16));
            if (c == 1) begin
                bus.a_in = 4'd6;
                bus.b_in = 4'd2;
            end
            if (c == 8) chk("b2b.p1", 32'(bus.product), 32'd15);
            if (c == 9) begin
                chk("b2b.ld_a2", 32'(bus.ld_a), 1);
                chk("b2b.a_out2", 32'(bus.a_out), 32'd6);
                bus.start = 1'b0;
            end
            if (c == 16) chk("b2b.p2", 32'(bus.product), 32'd12);
        end

        // reset in cycle 4 of a 9x9
        bus.start = 1'b1;
        bus.a_in  = 4'd9;
        bus.b_in  = 4'd9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 4) begin
                chk("mid.shift_c4", 32'(bus.shift_state), 1);
                reset = 1'b1;
            end else if (c == 5) begin
                chk_idle_zero("mid");
                reset = 1'b0;
            end else if (c > 5) begin
                chk($sformatf("mid.c%0d.ld_o", c), 32'(bus.ld_o), 0);
                chk($sformatf("mid.c%0d.done", c), 32'(bus.done), 0);
                chk($sformatf("mid.c%0d.prod", c), 32'(bus.product), 0);
            end
        end
        run_op("m9x9", 4'd9, 4'd9, 8'd81, 1'b0);

        // reset and start together: reset wins
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk_idle_zero("rst_start");
        @(negedge clk);
        chk("rst_start.busy2", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mul_sequencer.md
Name: shift_add_mul_sequencer

Overview:
Sequences the A/B/O register file and the RSH shift register to perform a 4x4 unsigned shift-and-add multiply into the 8-bit O register. Accepts a start/operand request, drives load strobes and shift control cycle by cycle, and keeps an internal accumulator. Presents a busy/done handshake to the top-level control unit.

Parameters:
IN_WIDTH, 4, operand width; also the number of CALC iterations.
OUT_WIDTH, 8, product/accumulator width; must equal 2*IN_WIDTH.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  synchronous, active-high.
start  input  1  request; accepted only in IDLE.
a_in  input  IN_WIDTH  multiplicand, sampled on the accept edge.
b_in  input  IN_WIDTH  multiplier, sampled on the accept edge.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse in DONE.
ld_a  output  1  register-file A load strobe.
ld_b  output  1  register-file B load strobe.
ld_o  output  1  register-file O load strobe.
a_out  output  IN_WIDTH  captured multiplicand, to register-file A input.
b_out  output  IN_WIDTH  captured multiplier, to register-file B / shift-register input.
shift_state  output  2  shift-register control: 00 hold, 01 RSH, 10 LSH.
o_data  output  OUT_WIDTH  product, to register-file O input.
product  output  OUT_WIDTH  registered last result.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, and busy, done, ld_a, ld_b, ld_o, a_out, b_out, shift_state, o_data, product, accumulator and counter all 0.
- FSM states: IDLE -> LOAD -> CALC (IN_WIDTH cycles) -> WRITE -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1, capture a_in into a_out and into mcand (zero-extended to OUT_WIDTH).
  - Capture b_in into b_out and into mplier.
  - Clear acc and cnt, then go to LOAD.
  - start=0 keeps the FSM in IDLE.
- LOAD (1 cycle): ld_a=ld_b=1, shift_state=00.
- CALC, each cycle:
  - shift_state=01.
  - On the edge: if mplier[0]=1, acc <= acc + mcand, modulo 2^OUT_WIDTH (no overflow for 4-bit operands; max 225).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - Leave for WRITE on the edge where cnt=IN_WIDTH-1.
- WRITE (1 cycle): ld_o=1, o_data=acc. On the edge, product <= acc.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- Latency: start high in cycle 0 gives LOAD in cycle 1, CALC in cycles 2..5, WRITE in cycle 6, DONE in cycle 7 and IDLE in cycle 8 (done at cycle IN_WIDTH+3).
- Strobe exclusivity:
  - ld_a/ld_b only in LOAD; ld_o only in WRITE; shift_state=01 only in CALC, otherwise 00.
  - 10 and 11 are never driven.
- Outputs hold between operations: o_data, product, a_out and b_out hold their last values in IDLE.
- start while busy=1 is ignored, not queued. start held high through DONE is re-accepted in the first IDLE cycle (cycle 8).
- Operand changes after the accept edge have no effect.
- Zero operands run the full IN_WIDTH iterations; there is no early termination.
- reset mid-operation (any state) returns to IDLE on that edge with every output at its reset value, including product. No partial result is written.
- reset and start in the same cycle: reset wins.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE, LOAD, CALC, WRITE, DONE (3-bit).
  - Shift codes: SHIFT_HOLD=2'b00, SHIFT_RSH=2'b01, SHIFT_LSH=2'b10 (shared with the shift register).
- One sub-module, shift_add_datapath, holds mcand, mplier, acc and cnt, with load/step controls and a last-iteration flag.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset: hold reset for 2 cycles -> all outputs 0, busy=0, state IDLE.
- start with a_in=15, b_in=15 in cycle 0:
  - ld_a/ld_b in cycle 1; shift_state=01 in cycles 2-5.
  - ld_o with o_data=225 (0xE1) in cycle 6; done in cycle 7; product=225.
- a_in=7, b_in=0 -> product=0, full 8-cycle latency. Then a_in=0, b_in=9 -> product=0.
- Back-to-back:
  - start held high with a=3, b=5, then a=6, b=2 -> products 15 and 12.
  - The second accept occurs in cycle 8, and done pulses in cycles 7 and 15.
- Ignored requests:
  - start pulsed in cycle 3 (busy) with a=1, b=1 -> ignored; first result unchanged; no second done.
  - a_in/b_in toggled during CALC -> result unaffected.
- Reset mid-operation: reset in cycle 4 of a 9x9 multiply -> IDLE next cycle, product=0, no ld_o and no done. A following 9x9 multiply yields 81.
